// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: unbuffered requester A, 2-deep FIFO for B.
// Define WB_ROUND_ROBIN_EN for round-robin; default is A priority with starvation guard.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        WE3,
    output logic [4:0]  AD3,
    output logic [31:0] WD3,
    output logic [31:0] pend_mask,
    output logic [1:0]  b_count
);

    logic [4:0]  r_faddr [2];
    logic [31:0] r_fdata [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_we;
    logic [4:0]  r_ad;
    logic [31:0] r_wd;

    logic        w_head_vld;
    logic        w_push;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_b_wins;
    logic        w_rd_nxt;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;
    logic [31:0] w_pend;

    assign w_head_vld = (r_count != 2'd0);
    assign w_rd_nxt   = ~r_rd_ptr;
    assign b_ready    = !rst && (r_count != 2'd2);
    assign w_push     = b_valid && b_ready;
    assign a_ready    = w_grant_a;
    assign b_count    = r_count;
    assign WE3        = r_we;
    assign AD3        = r_ad;
    assign WD3        = r_wd;
    assign pend_mask  = w_pend;

`ifdef WB_ROUND_ROBIN_EN
    // Set when B holds priority at the next contended cycle.
    logic r_rr_b;

    assign w_b_wins = r_rr_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_b <= 1'b0;
        end else if (a_valid && w_head_vld) begin
            r_rr_b <= w_grant_a;
        end
    end
`else
    logic [1:0] r_starve;

    assign w_b_wins = (r_starve == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || !w_head_vld || w_grant_b) begin
            r_starve <= 2'd0;
        end else if (r_starve != 2'd3) begin
            r_starve <= r_starve + 2'd1;
        end
    end
`endif

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!rst) begin
            if (a_valid && w_head_vld) begin
                w_grant_b = w_b_wins;
                w_grant_a = !w_b_wins;
            end else begin
                w_grant_a = a_valid;
                w_grant_b = w_head_vld;
            end
        end
    end

    always_comb begin
        w_sel_addr = r_faddr[r_rd_ptr];
        w_sel_data = r_fdata[r_rd_ptr];
        if (w_grant_a) begin
            w_sel_addr = a_addr;
            w_sel_data = a_data;
        end
    end

    always_comb begin
        w_pend = 32'd0;
        if (r_count != 2'd0) w_pend[r_faddr[r_rd_ptr]] = 1'b1;
        if (r_count == 2'd2) w_pend[r_faddr[w_rd_nxt]] = 1'b1;
        if (r_we)            w_pend[r_ad] = 1'b1;
        w_pend[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_grant_b};
            if (w_push)    r_wr_ptr <= ~r_wr_ptr;
            if (w_grant_b) r_rd_ptr <= ~r_rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_faddr[r_wr_ptr] <= b_addr;
            r_fdata[r_wr_ptr] <= b_data;
        end
    end

    // x0 writes still consume a grant but never assert the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we <= 1'b0;
            r_ad <= 5'd0;
            r_wd <= 32'd0;
        end else if (w_grant_a || w_grant_b) begin
            r_we <= (w_sel_addr != 5'd0);
            r_ad <= w_sel_addr;
            r_wd <= w_sel_data;
        end else begin
            r_we <= 1'b0;
        end
    end

endmodule
